train_seq_ctrl: RTL and testbench

Training-loop sequencer for the ANN backprop datapath. For every sample of every epoch it starts the forward pass and then the backward pass. It then pulses the enable of the weight/bias update unit, waits its latency, and commits the new weights/biases. It also holds the sample and epoch indices and supplies a per-epoch-decayed learning rate to the update unit.

---
 rtl/train_seq_ctrl.sv | 103 ++++++++++
 tb/tb_train_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/train_seq_ctrl.sv
// train_seq_ctrl: training-loop sequencer driving fwd/bwd passes, weight update/commit and per-epoch lr decay
module train_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 16,
  parameter int WB_LAT   = 2,
  parameter int DECAY_SH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_n_sample,
  input  logic [CNT_W-1:0] i_n_epoch,
  input  logic [WIDTH-1:0] i_lr,
  input  logic             i_fwd_done,
  input  logic             i_bwd_done,
  output logic             o_fwd_start,
  output logic             o_bwd_start,
  output logic             o_wb_en,
  output logic             o_wb_commit,
  output logic [WIDTH-1:0] o_lr,
  output logic [CNT_W-1:0] o_sample_idx,
  output logic [CNT_W-1:0] o_epoch_idx,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [2:0] {IDLE, FWD, BWD, WB, WAIT, COMMIT, DONE} state_t;
  localparam logic [3:0] LAT_M1 = 4'(WB_LAT > 0 ? WB_LAT - 1 : 0);
  state_t           r_state, w_next;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_last_s, r_last_e, w_last_s, w_last_e, w_sample, w_epoch;
  logic [WIDTH-1:0] w_lr, w_lr_dec;
  assign w_lr_dec = DECAY_SH == 0 ? o_lr : o_lr - WIDTH'($signed(o_lr) >>> DECAY_SH);
  always_comb begin
    w_next   = r_state;
    w_sample = o_sample_idx;
    w_epoch  = o_epoch_idx;
    w_lr     = o_lr;
    w_last_s = r_last_s;
    w_last_e = r_last_e;
    if (i_abort && r_state != IDLE) w_next = IDLE;
    else
      case (r_state)
        IDLE:
          if (i_start && !i_abort) begin
            w_lr     = i_lr;
            w_sample = '0;
            w_epoch  = '0;
            w_last_s = i_n_sample - CNT_W'(1);
            w_last_e = i_n_epoch - CNT_W'(1);
            w_next   = (i_n_sample == '0 || i_n_epoch == '0) ? DONE : FWD;
          end
        // the start pulse marks the first cycle, where done is not yet trusted
        FWD:  w_next = (i_fwd_done && !o_fwd_start) ? BWD : FWD;
        BWD:  w_next = (i_bwd_done && !o_bwd_start) ? WB : BWD;
        WB:   w_next = WB_LAT > 0 ? WAIT : COMMIT;
        WAIT: w_next = r_cnt == 4'd0 ? COMMIT : WAIT;
        COMMIT:
          if (o_sample_idx < r_last_s) begin
            w_sample = o_sample_idx + CNT_W'(1);
            w_next   = FWD;
          end else if (o_epoch_idx < r_last_e) begin
            w_sample = '0;
            w_epoch  = o_epoch_idx + CNT_W'(1);
            w_lr     = w_lr_dec;
            w_next   = FWD;
          end else w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_s     <= '0;
      r_last_e     <= '0;
      o_lr         <= '0;
      o_sample_idx <= '0;
      o_epoch_idx  <= '0;
      o_fwd_start  <= 1'b0;
      o_bwd_start  <= 1'b0;
      o_wb_en      <= 1'b0;
      o_wb_commit  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= r_state == WB ? LAT_M1 : r_cnt - 4'(r_state == WAIT);
      r_last_s     <= w_last_s;
      r_last_e     <= w_last_e;
      o_lr         <= w_lr;
      o_sample_idx <= w_sample;
      o_epoch_idx  <= w_epoch;
      o_fwd_start  <= w_next == FWD && r_state != FWD;
      o_bwd_start  <= w_next == BWD && r_state != BWD;
      o_wb_en      <= w_next == WB;
      o_wb_commit  <= w_next == COMMIT;
      o_busy       <= w_next != IDLE;
      o_done       <= w_next == DONE;
    end
  end
endmodule

// File: tb/tb_train_seq_ctrl.sv
// tb_train_seq_ctrl: scoreboard bench; each run pushes its expected pulse schedule, a negedge monitor pops and compares
module tb_train_seq_ctrl;
  logic        clk, rst, i_start, i_abort, i_fwd_done, i_bwd_done;
  logic [15:0] i_n_sample, i_n_epoch, o_sample_idx, o_epoch_idx;
  logic [31:0] i_lr, o_lr;
  logic        o_fwd_start, o_bwd_start, o_wb_en, o_wb_commit, o_busy, o_done;
  int          cyc = 0, n_vec = 0, n_err = 0;
  logic        held = 1'b0;
  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] s;
    logic [15:0] e;
    logic [31:0] lr;
  } ev_t;
  ev_t sb[$];

  train_seq_ctrl #(.WIDTH(32), .CNT_W(16), .WB_LAT(2), .DECAY_SH(1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_n_sample(i_n_sample), .i_n_epoch(i_n_epoch), .i_lr(i_lr),
    .i_fwd_done(i_fwd_done), .i_bwd_done(i_bwd_done),
    .o_fwd_start(o_fwd_start), .o_bwd_start(o_bwd_start), .o_wb_en(o_wb_en),
    .o_wb_commit(o_wb_commit), .o_lr(o_lr), .o_sample_idx(o_sample_idx),
    .o_epoch_idx(o_epoch_idx), .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // done answers arrive in the cycle right after each start pulse, or stay high when held
  initial begin
    logic pf, pb;
    i_fwd_done = 1'b0;
    i_bwd_done = 1'b0;
    forever begin
      @(negedge clk);
      pf = o_fwd_start === 1'b1;
      pb = o_bwd_start === 1'b1;
      @(posedge clk);
      #1;
      i_fwd_done = held | pf;
      i_bwd_done = held | pb;
    end
  end

  initial begin
    logic [4:0] p;
    ev_t ev;
    forever begin
      @(negedge clk);
      p = {o_done, o_wb_commit, o_wb_en, o_bwd_start, o_fwd_start};
      for (int k = 0; k < 5; k++)
        if (p[k] === 1'b1) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pulse kind=%0d cyc=%0d idx=%0d/%0d", k, cyc, o_sample_idx, o_epoch_idx);
          end else begin
            ev = sb.pop_front();
            if (ev.kind !== k || ev.cyc !== cyc || ev.s !== o_sample_idx || ev.e !== o_epoch_idx || ev.lr !== o_lr) begin
              n_err++;
              $display("FAIL pulse got kind=%0d cyc=%0d s=%0d e=%0d lr=%h want kind=%0d cyc=%0d s=%0d e=%0d lr=%h",
                       k, cyc, o_sample_idx, o_epoch_idx, o_lr, ev.kind, ev.cyc, ev.s, ev.e, ev.lr);
            end
          end
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int kind, int c, int s, int e, logic [31:0] lr);
    ev_t ev;
    ev.kind = kind;
    ev.cyc  = c;
    ev.s    = 16'(s);
    ev.e    = 16'(e);
    ev.lr   = lr;
    sb.push_back(ev);
  endtask

  // drive a start and push the expected schedule; abort_m >= 0 truncates after the wb_en of that sample
  task automatic launch(int ns, int ne, logic [31:0] lr, int abort_m);
    int t0, m;
    logic signed [31:0] l;
    t0 = cyc;
    i_n_sample = 16'(ns);
    i_n_epoch  = 16'(ne);
    i_lr       = lr;
    i_start    = 1'b1;
    l = lr;
    m = 0;
    if (ns == 0 || ne == 0) push(4, t0 + 1, 0, 0, lr);
    else begin
      for (int e = 0; e < ne && m >= 0; e++) begin
        for (int s = 0; s < ns && m >= 0; s++) begin
          push(0, t0 + 8*m + 1, s, e, l);
          push(1, t0 + 8*m + 3, s, e, l);
          push(2, t0 + 8*m + 5, s, e, l);
          if (m == abort_m) m = -1;
          else begin
            push(3, t0 + 8*m + 8, s, e, l);
            m++;
          end
        end
        if (m >= 0 && e < ne - 1) l = l - (l >>> 1);
      end
      if (m >= 0) push(4, t0 + 8*m + 1, ns - 1, ne - 1, l);
    end
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 400 && o_busy === 1'b1; i++) tick();
    n_vec++;
    if (o_busy !== 1'b0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_finish busy=%b pending=%0d want busy=0 pending=0", name, o_busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({o_fwd_start, o_bwd_start, o_wb_en, o_wb_commit, o_busy, o_done, o_lr, o_sample_idx, o_epoch_idx} !== 70'd0) begin
        n_err++;
        $display("FAIL reset_state busy=%b done=%b lr=%h s=%0d e=%0d want all 0", o_busy, o_done, o_lr, o_sample_idx, o_epoch_idx);
      end
    end
  endtask

  task automatic test_two_samples();
    launch(2, 1, 32'h0019999a, -1);
    wait_idle("two_samples");
    n_vec++;
    if (o_lr !== 32'h0019999a || o_sample_idx !== 16'd1) begin
      n_err++;
      $display("FAIL two_samples_hold lr=%h s=%0d want lr=0019999a s=1", o_lr, o_sample_idx);
    end
  endtask

  task automatic test_decay();
    launch(1, 3, 32'h00400000, -1);
    wait_idle("decay");
    n_vec++;
    if (o_lr !== 32'h00100000 || o_epoch_idx !== 16'd2) begin
      n_err++;
      $display("FAIL decay_final lr=%h e=%0d want lr=00100000 e=2", o_lr, o_epoch_idx);
    end
  endtask

  task automatic test_held_done();
    held = 1'b1;
    launch(2, 2, 32'hfffffffd, -1);
    wait_idle("held_done");
    held = 1'b0;
    n_vec++;
    if (o_lr !== 32'hffffffff) begin
      n_err++;
      $display("FAIL held_neg_decay lr=%h want ffffffff", o_lr);
    end
  endtask

  task automatic test_abort(int ns, int ne, string name);
    int t0;
    t0 = cyc;
    launch(ns, ne, 32'h00012345, 1);
    while (cyc < t0 + 14) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_vec++;
    if (o_busy !== 1'b0 || o_sample_idx !== 16'd1 || o_lr !== 32'h00012345) begin
      n_err++;
      $display("FAIL %s_abort busy=%b s=%0d lr=%h want busy=0 s=1 lr=00012345", name, o_busy, o_sample_idx, o_lr);
    end
    for (int i = 0; i < 6; i++) tick();
    wait_idle(name);
    launch(1, 1, 32'h00000777, -1);
    wait_idle({name, "_restart"});
  endtask

  task automatic test_zero_and_busy_start();
    launch(3, 0, 32'h00000042, -1);
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_epoch_busy busy=%b want 1", o_busy);
    end
    tick();
    wait_idle("zero_epoch");
    launch(1, 1, 32'h00000055, -1);
    tick();
    i_start    = 1'b1;
    i_n_sample = 16'd5;
    i_lr       = 32'h0000aaaa;
    tick();
    i_start = 1'b0;
    wait_idle("busy_start");
    n_vec++;
    if (o_lr !== 32'h00000055) begin
      n_err++;
      $display("FAIL busy_start_lr lr=%h want 00000055", o_lr);
    end
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    tick();
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_with_abort busy=%b want 0", o_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_n_sample = '0;
    i_n_epoch = '0;
    i_lr = '0;
    test_reset();
    test_two_samples();
    test_decay();
    test_held_done();
    test_abort(3, 1, "abort");
    test_abort(16'hffff, 16'hffff, "max_count");
    test_zero_and_busy_start();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
